// File: rtl/tpp_pkg.sv
// Shared constants for the TPP datapath: header field offsets, the hop-update
// FSM state encoding and the TPP instruction opcodes.
package tpp_pkg;

   localparam logic [15:0] TPP_ETHERTYPE_DEF = 16'h6666;
   localparam int unsigned ETHERTYPE_LSB     = 96;
   localparam int unsigned HOP_LSB           = 0;
   localparam int unsigned DST_PORT_LSB_DEF  = 24;

   localparam logic [2:0] ST_CAP0  = 3'd0;
   localparam logic [2:0] ST_CAP1  = 3'd1;
   localparam logic [2:0] ST_EMIT0 = 3'd2;
   localparam logic [2:0] ST_EMIT1 = 3'd3;
   localparam logic [2:0] ST_PASS  = 3'd4;

   localparam logic [7:0] TPP_OP_NOP   = 8'h00;
   localparam logic [7:0] TPP_OP_PUSH  = 8'h01;
   localparam logic [7:0] TPP_OP_LOAD  = 8'h02;
   localparam logic [7:0] TPP_OP_STORE = 8'h03;
   localparam logic [7:0] TPP_OP_POP   = 8'h04;
   localparam logic [7:0] TPP_OP_CEXEC = 8'h05;

endpackage

// File: rtl/tpp_hop_update.sv
// Increments the saturating TPP hop count in beat 1 and clears the destination
// port of packets over the hop limit; fully registered AXI-Stream master.
module tpp_hop_update
   import tpp_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 256,
   parameter int          C_M_AXIS_DATA_WIDTH  = 256,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter int          C_M_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] TPP_ETHERTYPE        = TPP_ETHERTYPE_DEF,
   parameter logic [7:0]  HOP_LIMIT            = 8'd16,
   parameter int          DST_PORT_LSB         = DST_PORT_LSB_DEF
) (
   input  logic                                 axi_aclk,
   input  logic                                 reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready,
   output logic [31:0]                          tpp_pkt_count,
   output logic [31:0]                          tpp_drop_count
);

   function automatic logic [7:0] hop_sat_inc(input logic [7:0] hop);
      return (hop == 8'hFF) ? 8'hFF : hop + 8'd1;
   endfunction

   logic [2:0]                            state;
   logic [C_S_AXIS_DATA_WIDTH-1:0]        a_data_p0, b_data_p1;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0]      a_strb_p0, b_strb_p1;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]       a_user_p0, b_user_p1;
   logic                                  a_last_p0, b_last_p1;
   logic                                  is_tpp_p0;

   logic       out_free;
   logic       accept;
   logic       eth_match;
   logic [7:0] hop_new;
   logic       hop_over;

   assign out_free  = ~m_axis_tvalid | m_axis_tready;
   assign accept    = s_axis_tvalid & s_axis_tready;
   assign eth_match = (s_axis_tdata[ETHERTYPE_LSB +: 16] == TPP_ETHERTYPE);
   assign hop_new   = hop_sat_inc(s_axis_tdata[HOP_LSB +: 8]);
   assign hop_over  = (hop_new > HOP_LIMIT);

   always_comb begin
      s_axis_tready = 1'b0;
      if (!reset) begin
         case (state)
            ST_CAP0, ST_CAP1: s_axis_tready = 1'b1;
            ST_PASS:          s_axis_tready = out_free;
            default:          s_axis_tready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state          <= ST_CAP0;
         a_data_p0      <= '0;
         a_strb_p0      <= '0;
         a_user_p0      <= '0;
         a_last_p0      <= 1'b0;
         b_data_p1      <= '0;
         b_strb_p1      <= '0;
         b_user_p1      <= '0;
         b_last_p1      <= 1'b0;
         is_tpp_p0      <= 1'b0;
         m_axis_tdata   <= '0;
         m_axis_tstrb   <= '0;
         m_axis_tuser   <= '0;
         m_axis_tvalid  <= 1'b0;
         m_axis_tlast   <= 1'b0;
         tpp_pkt_count  <= '0;
         tpp_drop_count <= '0;
      end else begin
         // Output stage: valid drops once consumed unless reloaded below.
         if (m_axis_tready)
            m_axis_tvalid <= 1'b0;

         case (state)
            ST_CAP0: if (accept) begin
               a_data_p0 <= s_axis_tdata;
               a_strb_p0 <= s_axis_tstrb;
               a_user_p0 <= s_axis_tuser;
               a_last_p0 <= s_axis_tlast;
               is_tpp_p0 <= eth_match;
               state     <= s_axis_tlast ? ST_EMIT0 : ST_CAP1;
            end
            ST_CAP1: if (accept) begin
               // Beat 1 capture; the drop decision rewrites the held beat 0.
               b_data_p1 <= s_axis_tdata;
               b_strb_p1 <= s_axis_tstrb;
               b_user_p1 <= s_axis_tuser;
               b_last_p1 <= s_axis_tlast;
               if (is_tpp_p0) begin
                  b_data_p1[HOP_LSB +: 8] <= hop_new;
                  tpp_pkt_count           <= tpp_pkt_count + 32'd1;
                  if (hop_over) begin
                     a_user_p0[DST_PORT_LSB +: 8] <= 8'h00;
                     tpp_drop_count               <= tpp_drop_count + 32'd1;
                  end
               end
               state <= ST_EMIT0;
            end
            ST_EMIT0: if (out_free) begin
               m_axis_tdata  <= a_data_p0;
               m_axis_tstrb  <= a_strb_p0;
               m_axis_tuser  <= a_user_p0;
               m_axis_tlast  <= a_last_p0;
               m_axis_tvalid <= 1'b1;
               state         <= a_last_p0 ? ST_CAP0 : ST_EMIT1;
            end
            ST_EMIT1: if (out_free) begin
               m_axis_tdata  <= b_data_p1;
               m_axis_tstrb  <= b_strb_p1;
               m_axis_tuser  <= b_user_p1;
               m_axis_tlast  <= b_last_p1;
               m_axis_tvalid <= 1'b1;
               state         <= b_last_p1 ? ST_CAP0 : ST_PASS;
            end
            ST_PASS: if (accept) begin
               m_axis_tdata  <= s_axis_tdata;
               m_axis_tstrb  <= s_axis_tstrb;
               m_axis_tuser  <= s_axis_tuser;
               m_axis_tlast  <= s_axis_tlast;
               m_axis_tvalid <= 1'b1;
               if (s_axis_tlast)
                  state <= ST_CAP0;
            end
            default: state <= ST_CAP0;
         endcase
      end
   end

endmodule

// File: doc/tpp_hop_update.md
# tpp_hop_update

Post-processing stage that sits directly downstream of the last `tpp` stage in the datapath and upstream of the output queues. It recognises TPP packets by ethertype in the first beat and increments the 8-bit hop count carried in the second beat, saturating at 255. If the new hop count exceeds a limit, it clears the destination-port field in the first beat's tuser. It also keeps packet and drop counters, and presents a fully registered AXI-Stream master.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256: input data width. It must equal `C_M_AXIS_DATA_WIDTH`.
- `C_M_AXIS_DATA_WIDTH`, 256: output data width.
- `C_S_AXIS_TUSER_WIDTH` / `C_M_AXIS_TUSER_WIDTH`, 128: tuser width. The two must be equal.
- `TPP_ETHERTYPE`, 16'h6666: ethertype value as it appears in bus order at beat 0 `tdata[111:96]`.
- `HOP_LIMIT`, 8'd16: a packet is dropped when its incremented hop count is greater than this value.
- `DST_PORT_LSB`, 24: bit offset of the 8-bit destination-port field in tuser.
- `axi_aclk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_axis_tdata/tstrb/tuser/tvalid/tlast`  in  256/32/128/1/1  stream from the last `tpp` stage.
- `s_axis_tready`  out  1
- `m_axis_tdata/tstrb/tuser/tvalid/tlast`  out  256/32/128/1/1  registered outputs.
- `m_axis_tready`  in  1
- `tpp_pkt_count`  out  32  number of TPP packets seen; wraps at 2^32.
- `tpp_drop_count`  out  32  number of TPP packets whose destination port was cleared; wraps at 2^32.

## Operation
- Holding registers: A holds beat 0 (data, strb, user, last). B holds beat 1. Register `is_tpp` holds the result of the ethertype match on beat 0.
- CAP0: `s_axis_tready`=1. On an accepted beat, capture it into A and set `is_tpp` = (`tdata[111:96]`==`TPP_ETHERTYPE`). If the beat has tlast, go to EMIT0; otherwise go to CAP1.
- CAP1: `s_axis_tready`=1. On an accepted beat, capture it into B, then go to EMIT0.
  - If `is_tpp`: hop_new = (`tdata[7:0]`==8'hFF) ? 8'hFF : `tdata[7:0]`+1. Write hop_new to B `tdata[7:0]`. Increment `tpp_pkt_count`.
  - If `is_tpp` and hop_new > `HOP_LIMIT`: clear A `tuser[DST_PORT_LSB+7:DST_PORT_LSB]` to 0 and increment `tpp_drop_count`.
  - Comparisons are unsigned 8-bit.
- EMIT0: `s_axis_tready`=0. When the output register is free (`~m_axis_tvalid | m_axis_tready`), load A into it. Then go to CAP0 if A has tlast, else to EMIT1.
- EMIT1: `s_axis_tready`=0. When the output register is free, load B. Then go to CAP0 if B has tlast, else to PASS.
- PASS: `s_axis_tready` = output register free. Each accepted beat is loaded unmodified. A beat with tlast returns the FSM to CAP0.
- Output register rules:
  - When not reloaded, `m_axis_tvalid` clears on `m_axis_tready`.
  - Data is held stable while `tvalid & ~tready`.
- A single-beat packet is never modified and never counted.
- Non-TPP packets pass bit-exact.
- Counter increments and the B/A field modifications occur in the same CAP1 accept cycle.

## Timing
- Let beat 0 be accepted in cycle c0 and beat 1 in cycle c1, with the output free.
  - `m_axis` presents beat 0 in c3 and beat 1 in c4.
  - PASS accepts input from c4 onward.
  - Result: 2 input bubble cycles per multi-beat packet (EMIT0, EMIT1), and one extra cycle of output latency.
- Single-beat packet: accepted in c0, EMIT0 in c1, output in c2.
- Back-to-back packets: CAP0 of packet n+1 may capture while the output register still holds the last beat of packet n.
- The counters are registered and update at the end of the CAP1 accept cycle.
- Reset values: all `m_axis_*` = 0, `tpp_pkt_count` = `tpp_drop_count` = 0, state = CAP0, A/B/`is_tpp` = 0. `s_axis_tready` is forced to 0 while `reset`=1.
- Reset mid-packet: the partial packet and any held beats are discarded, and no tlast is emitted. After reset, the next beat accepted is treated as beat 0.

## Structure
- Shared package `tpp_pkg`: default `TPP_ETHERTYPE`, ethertype bit offset 96, hop-count offset 0 in beat 1, default `DST_PORT_LSB`, and the FSM state encoding (CAP0=0, CAP1=1, EMIT0=2, EMIT1=3, PASS=4, 3-bit). The `tpp` opcode constants also move into this package.
- No sub-module. The FSM, the holding registers and the output register stay in one module.

## Test plan
- Non-TPP 3-beat packet (ethertype 16'h0800) -> output is bit-identical and both counters stay 0.
- TPP 4-beat packet with hop 8'd3 and tuser dst 8'h04 -> beat 1 `tdata[7:0]`=8'd4, dst unchanged, `tpp_pkt_count`=1.
- TPP packet with hop 8'd16 (`HOP_LIMIT`=16) -> hop 8'd17, beat 0 tuser[31:24]=0, `tpp_drop_count`=1. A second packet with hop 8'hFF -> hop stays 8'hFF, `tpp_drop_count`=2.
- Single-beat TPP packet -> passed unmodified, 2-cycle latency, counters unchanged. Follow it immediately with a 2-beat TPP packet -> both packets emitted in order, with the second one modified.
- Random `m_axis_tready` (50%) over 100 mixed packets -> no beat lost, duplicated or changed while stalled, and the counters match the scoreboard.
- Assert `reset` during PASS of a 5-beat packet -> outputs go to 0, counters go to 0, `s_axis_tready`=0 during reset. The next packet is processed correctly from CAP0.
